// File: rtl/sass_transmitter.sv
// sass_transmitter
// Transmit end of the single-wire SASS command link. Each valid/ready handshake accepts one
// command word d[9:0] = {dir_cmd, speed_cmd, mode}. The word is Hamming(14,10)-encoded and
// sent LSB-first on `s` as a start bit (0), 14 code bits and an end bit (0), followed by
// gap_b idle-high bit periods. One bit lasts T_D = clk_f*t/range clocks.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   cmd_valid  in   command word present
//   cmd_ready  out  transmitter can accept a word
//   mode       in   [1:0] operating mode
//   speed_cmd  in   [cmd_l-1:0] speed command
//   dir_cmd    in   [cmd_l-1:0] direction command
//   err_in     in   [3:0] error injection select (only with SASS_TX_ERR_INJ_EN)
//   s          out  SASS line, idle high
//   busy       out  frame or gap in progress
//   done       out  one-cycle pulse when a frame plus its gap completes
//
// Optional feature macro: SASS_TX_ERR_INJ_EN. When defined, err_in = k (1..14) inverts code
// bit c[k-1] of the captured word; other values inject nothing.

module sass_transmitter #(
    parameter int unsigned clk_f  = 50_000_000,
    parameter int unsigned range  = 1_000_000,
    parameter real         t      = 0.1,
    parameter int unsigned data_l = 14,
    parameter int unsigned cmd_l  = 4,
    parameter int unsigned gap_b  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       mode,
    input  logic [cmd_l-1:0] speed_cmd,
    input  logic [cmd_l-1:0] dir_cmd,
`ifdef SASS_TX_ERR_INJ_EN
    input  logic [3:0]       err_in,
`endif
    output logic             s,
    output logic             busy,
    output logic             done
);

    localparam int          BitPeriod = int'(real'(clk_f) * t / real'(range));
    localparam int unsigned TimerW    = (BitPeriod < 2) ? 1 : $clog2(BitPeriod);
    localparam int unsigned IdxMax    = (gap_b > 14) ? gap_b : 14;
    localparam int unsigned IdxW      = $clog2(IdxMax + 1);
    localparam int unsigned GapLast   = (gap_b > 0) ? gap_b - 1 : 0;

    if (BitPeriod < 2) begin : g_bad_period
        $error("sass_transmitter: bit period clk_f*t/range must be at least 2 clocks");
    end
    if (data_l != 14 || cmd_l != 4) begin : g_bad_width
        $error("sass_transmitter: data_l must be 14 and cmd_l must be 4");
    end

    typedef enum logic [2:0] {StIdle, StStart, StData, StEnd, StGap} state_e;

    state_e            state_q;
    logic [TimerW-1:0] timer_q;
    logic [IdxW-1:0]   idx_q;
    logic [data_l-1:0] shift_q;

    logic [9:0]  data_w;
    logic [13:0] code_w;
    logic        timer_last;
    logic        timer_pre_last;

    // Classic Hamming layout: parity bits sit at 1-based positions 1, 2, 4 and 8.
    function automatic logic [13:0] hamming_encode(input logic [9:0] d);
        logic p0, p1, p2, p3;
        p0 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8];
        p1 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9];
        p2 = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9];
        p3 = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9];
        return {d[9:4], p3, d[3:1], p2, d[0], p1, p0};
    endfunction

    assign data_w = {dir_cmd, speed_cmd, mode};

    always_comb begin
        code_w = hamming_encode(data_w);
`ifdef SASS_TX_ERR_INJ_EN
        if (err_in != 4'd0 && err_in <= 4'd14) begin
            code_w = code_w ^ (14'd1 << (err_in - 4'd1));
        end
`endif
    end

    assign timer_last     = (timer_q == TimerW'(BitPeriod - 1));
    assign timer_pre_last = (timer_q == TimerW'(BitPeriod - 2));

    // The last clock of every frame (last gap clock, or last end-bit clock when gap_b == 0)
    // is spent back in IDLE with cmd_ready and done already high. A waiting word is therefore
    // accepted on the very edge that completes the frame, so consecutive start bits are
    // exactly (16+gap_b)*T_D clocks apart. `s` is left untouched on the exit edge so the end
    // bit keeps its full length when there is no gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            s         <= 1'b1;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    timer_q <= '0;
                    idx_q   <= '0;
                    if (cmd_valid && cmd_ready) begin
                        shift_q   <= code_w;
                        s         <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state_q   <= StStart;
                    end else begin
                        s         <= 1'b1;
                        cmd_ready <= 1'b1;
                    end
                end
                StStart: begin
                    if (timer_last) begin
                        timer_q <= '0;
                        idx_q   <= '0;
                        s       <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= StData;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StData: begin
                    if (timer_last) begin
                        timer_q <= '0;
                        if (idx_q == IdxW'(13)) begin
                            s       <= 1'b0;
                            state_q <= StEnd;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            s       <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StEnd: begin
                    if (gap_b == 0) begin
                        if (timer_pre_last) begin
                            timer_q   <= '0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                            state_q   <= StIdle;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end else if (timer_last) begin
                        timer_q <= '0;
                        idx_q   <= '0;
                        s       <= 1'b1;
                        state_q <= StGap;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StGap: begin
                    if (idx_q == IdxW'(GapLast) && timer_pre_last) begin
                        timer_q   <= '0;
                        idx_q     <= '0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_q   <= StIdle;
                    end else if (timer_last) begin
                        timer_q <= '0;
                        idx_q   <= idx_q + 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    s       <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
